// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, status-field positions and error-bit indices
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } uart_state_t;

    // Status/config word field positions (shared with the transmitter)
    localparam int STAT_EN        = 0;
    localparam int STAT_DBITS_LSB = 1;
    localparam int STAT_DBITS_MSB = 4;
    localparam int STAT_PAR_EN    = 5;
    localparam int STAT_STOP_LSB  = 6;
    localparam int STAT_STOP_MSB  = 7;

    // Receiver_Error bit indices
    localparam int ERR_PARITY  = 0;
    localparam int ERR_FRAMING = 1;
    localparam int ERR_OVERRUN = 2;

    // Data-bit field: legal 5..8, anything else falls back to 8
    function automatic logic [3:0] decode_dbits(input logic [3:0] field);
        return (field >= 4'd5 && field <= 4'd8) ? field : 4'd8;
    endfunction

    // Stop field: only 2'b10 selects two stop bits
    function automatic logic decode_stop2(input logic [1:0] field);
        return (field == 2'b10);
    endfunction

endpackage

// File: rtl/uart_rx_baud_gen.sv
// rtl/uart_rx_baud_gen.sv - bit-period divisor, bit counter and sample tick for the UART receiver
module uart_rx_baud_gen #(
    parameter int unsigned clock_frequency_register = 100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] baud,
    input  logic        run,
    input  logic        half_phase,
    output logic        sample_tick
);

    localparam logic [31:0] CLK_HZ = 32'(clock_frequency_register);

    logic [31:0] divisor;
    logic [31:0] half;
    logic [31:0] target;
    logic [31:0] count;

    // Divisor from the latched baud; the start bit is checked at half a period, all others at a full period
    always_comb begin
        divisor = (baud == 32'd0) ? 32'd0 : CLK_HZ / baud;
        half    = divisor >> 1;
        if (half_phase) begin
            target = (half == 32'd0) ? 32'd0 : half - 32'd1;
        end else begin
            target = (divisor == 32'd0) ? 32'd0 : divisor - 32'd1;
        end
        sample_tick = run && (count == target);
    end

    // Bit counter: restarts after every sample and whenever the receiver is not inside a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 32'd0;
        end else if (!run || sample_tick) begin
            count <= 32'd0;
        end else begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART receive half; optional RX_MAJORITY_VOTE_EN selects 3-sample majority voting
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned clock_frequency_register = 100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic [31:0] Baud_Rate_Holding_Register,
    input  logic [31:0] Receiver_Status,
    input  logic        Receiver_Read,
    output logic [31:0] Receiver_Buffer_Register,
    output logic        data_ready,
    output logic [2:0]  Receiver_Error
);

    uart_state_t state, state_n;

    logic        rx_s1, rx_s2, rx_prev;
    logic        rx_bit;
    logic        rx_fall;
    logic        en;
    logic        sample_tick;
    logic        run;

    logic [31:0] baud_q;
    logic [3:0]  dbits_q;
    logic        par_en_q;
    logic        stop2_q;
    logic [3:0]  bit_idx;
    logic [7:0]  shreg;
    logic        par_acc;
    logic        par_err_q;
    logic        frm_err_q;
    logic        last_data;
    logic        last_stop;
    logic [2:0]  frame_err;

    logic        unused_status;
    assign unused_status = ^Receiver_Status[31:8];

    assign en      = Receiver_Status[STAT_EN];
    assign rx_fall = rx_prev && !rx_s2;
    assign run     = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic rx_hist;

    // Extra history flop; the vote window ends on the tick so the DONE timing matches the single-sample build
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_hist <= 1'b1;
        end else begin
            rx_hist <= rx_prev;
        end
    end

    assign rx_bit = (rx_s2 & rx_prev) | (rx_s2 & rx_hist) | (rx_prev & rx_hist);
`else
    assign rx_bit = rx_s2;
`endif

    uart_rx_baud_gen #(
        .clock_frequency_register(clock_frequency_register)
    ) u_baud_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud       (baud_q),
        .run        (run),
        .half_phase (state == START),
        .sample_tick(sample_tick)
    );

    assign last_data = (bit_idx == dbits_q - 4'd1);
    assign last_stop = (bit_idx == {3'b000, stop2_q});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; dropping enable abandons any frame in progress
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (en && (Baud_Rate_Holding_Register != 32'd0) && rx_fall) begin
                    state_n = START;
                end
            end
            START: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (sample_tick) begin
                    state_n = rx_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (sample_tick && last_data) begin
                    state_n = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (sample_tick) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (sample_tick && last_stop) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Frame datapath: latch config at frame start, shift data LSB first, accumulate parity and stop checks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q    <= 32'd0;
            dbits_q   <= 4'd8;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            bit_idx   <= 4'd0;
            shreg     <= 8'd0;
            par_acc   <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else if (state == IDLE) begin
            if (state_n == START) begin
                baud_q    <= Baud_Rate_Holding_Register;
                dbits_q   <= decode_dbits(Receiver_Status[STAT_DBITS_MSB:STAT_DBITS_LSB]);
                par_en_q  <= Receiver_Status[STAT_PAR_EN];
                stop2_q   <= decode_stop2(Receiver_Status[STAT_STOP_MSB:STAT_STOP_LSB]);
                bit_idx   <= 4'd0;
                shreg     <= 8'd0;
                par_acc   <= 1'b0;
                par_err_q <= 1'b0;
                frm_err_q <= 1'b0;
            end
        end else if (sample_tick) begin
            case (state)
                DATA: begin
                    shreg[bit_idx[2:0]] <= rx_bit;
                    par_acc             <= par_acc ^ rx_bit;
                    bit_idx             <= last_data ? 4'd0 : bit_idx + 4'd1;
                end
                PARITY: par_err_q <= par_acc ^ rx_bit;
                STOP: begin
                    if (!rx_bit) begin
                        frm_err_q <= 1'b1;
                    end
                    bit_idx <= bit_idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Flags produced by the frame being completed
    always_comb begin
        frame_err              = 3'b000;
        frame_err[ERR_PARITY]  = par_err_q;
        frame_err[ERR_FRAMING] = frm_err_q;
        frame_err[ERR_OVERRUN] = data_ready;
    end

    // Host-visible registers: DONE stores the frame (winning over a coincident read), otherwise read clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Receiver_Buffer_Register <= 32'd0;
            data_ready               <= 1'b0;
            Receiver_Error           <= 3'b000;
        end else if (state == DONE) begin
            Receiver_Buffer_Register <= {24'd0, shreg};
            data_ready               <= 1'b1;
            if (Receiver_Read) begin
                Receiver_Error <= {1'b0, frame_err[ERR_FRAMING], frame_err[ERR_PARITY]};
            end else begin
                Receiver_Error <= Receiver_Error | frame_err;
            end
        end else if (Receiver_Read) begin
            data_ready     <= 1'b0;
            Receiver_Error <= 3'b000;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver with a frame-level reference model
module tb_uart_receiver;

    localparam int unsigned CLK_HZ = 100_000_000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        RX = 1'b1;
    logic        Receiver_Read = 1'b0;
    logic [31:0] Baud_Rate_Holding_Register = 32'd0;
    logic [31:0] Receiver_Status = 32'd0;
    logic [31:0] Receiver_Buffer_Register;
    logic        data_ready;
    logic [2:0]  Receiver_Error;

    uart_receiver #(.clock_frequency_register(CLK_HZ)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .RX                        (RX),
        .Baud_Rate_Holding_Register(Baud_Rate_Holding_Register),
        .Receiver_Status           (Receiver_Status),
        .Receiver_Read             (Receiver_Read),
        .Receiver_Buffer_Register  (Receiver_Buffer_Register),
        .data_ready                (data_ready),
        .Receiver_Error            (Receiver_Error)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic read_q = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) read_q <= Receiver_Read;

    int n_cmp = 0;
    int n_bad = 0;

    // Pending frame prediction, written only by the stimulus
    int         pend_cycle = -1;
    logic [7:0] pend_data = 8'd0;
    logic       pend_par = 1'b0;
    logic       pend_frm = 1'b0;

    // Literal pins, written only by the stimulus
    logic        pin_valid = 1'b0;
    string       pin_name = "";
    logic [31:0] pin_buf = 32'd0;
    logic        pin_ready = 1'b0;
    logic [2:0]  pin_err = 3'b000;

    // Model state, written only by the compare process
    logic [31:0] m_buf = 32'd0;
    logic        m_ready = 1'b0;
    logic [2:0]  m_err = 3'b000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 20)
                $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Model update and comparison, once per cycle away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            m_buf   = 32'd0;
            m_ready = 1'b0;
            m_err   = 3'b000;
        end else if (cyc == pend_cycle) begin
            if (read_q) m_err = {1'b0, pend_frm, pend_par};
            else        m_err = m_err | {m_ready, pend_frm, pend_par};
            m_buf   = {24'd0, pend_data};
            m_ready = 1'b1;
        end else if (read_q) begin
            m_ready = 1'b0;
            m_err   = 3'b000;
        end
        check("buffer", Receiver_Buffer_Register, m_buf);
        check("data_ready", 32'(data_ready), 32'(m_ready));
        check("error", 32'(Receiver_Error), 32'(m_err));
        if (pin_valid) begin
            check({pin_name, "_buffer"}, Receiver_Buffer_Register, pin_buf);
            check({pin_name, "_ready"}, 32'(data_ready), 32'(pin_ready));
            check({pin_name, "_error"}, 32'(Receiver_Error), 32'(pin_err));
        end
    end

    function automatic int eff_dbits(input logic [3:0] f);
        return (f >= 4'd5 && f <= 4'd8) ? int'(f) : 8;
    endfunction

    function automatic int eff_stop(input logic [1:0] f);
        return (f == 2'b10) ? 2 : 1;
    endfunction

    task automatic hold_bit(input logic v, input int d);
        RX = v;
        repeat (d) @(posedge clk);
        #1;
    endtask

    task automatic pin(input string name, input logic [31:0] b, input logic r, input logic [2:0] e);
        @(posedge clk); #1;
        pin_name  = name;
        pin_buf   = b;
        pin_ready = r;
        pin_err   = e;
        pin_valid = 1'b1;
        @(posedge clk); #1;
        pin_valid = 1'b0;
    endtask

    task automatic do_read();
        @(posedge clk); #1;
        Receiver_Read = 1'b1;
        @(posedge clk); #1;
        Receiver_Read = 1'b0;
    endtask

    // Drive one complete frame and predict its outcome: the last sample lands half + m*d cycles after
    // the start edge, plus two synchroniser cycles, the IDLE->START cycle and the DONE cycle
    task automatic send_frame(input logic [7:0] data, input logic par_bit, input logic [1:0] stop_bits,
                              input bit scramble);
        int n, ns, d, half, m, k;
        bit pe;
        logic [7:0] dm;
        logic [31:0] save_baud, save_stat;
        n    = eff_dbits(Receiver_Status[4:1]);
        pe   = Receiver_Status[5];
        ns   = eff_stop(Receiver_Status[7:6]);
        d    = int'(CLK_HZ / Baud_Rate_Holding_Register);
        half = d / 2;
        dm   = 8'((16'(data)) & ((16'd1 << n) - 16'd1));
        m    = n + int'(pe) + ns;
        save_baud = Baud_Rate_Holding_Register;
        save_stat = Receiver_Status;
        @(posedge clk); #1;
        k = cyc;
        pend_data  = dm;
        pend_par   = pe && ((^dm) ^ par_bit);
        pend_frm   = !stop_bits[0] || (ns == 2 && !stop_bits[1]);
        pend_cycle = k + half + m * d + 4;
        hold_bit(1'b0, d);
        if (scramble) begin
            Baud_Rate_Holding_Register = 32'd12345;
            Receiver_Status = Receiver_Status ^ 32'h0000_00FE;
        end
        for (int i = 0; i < n; i++) hold_bit(dm[i], d);
        if (pe) hold_bit(par_bit, d);
        for (int s = 0; s < ns; s++) hold_bit(stop_bits[s], d);
        RX = 1'b1;
        Baud_Rate_Holding_Register = save_baud;
        Receiver_Status = save_stat;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (4) @(posedge clk);
        pin("reset", 32'd0, 1'b0, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        Baud_Rate_Holding_Register = 32'd7_000_000;
        Receiver_Status = 32'h51;
        repeat (5) @(posedge clk);

        // 8N1 0x50
        send_frame(8'h50, 1'b0, 2'b11, 1'b0);
        pin("t1_8n1", 32'h50, 1'b1, 3'b000);
        do_read();

        // 8E1 0xA5 with wrong parity bit, config scrambled mid-frame
        Receiver_Status = 32'h71;
        send_frame(8'hA5, 1'b1, 2'b11, 1'b1);
        pin("t2_parity", 32'hA5, 1'b1, 3'b001);
        do_read();
        pin("t2_cleared", 32'hA5, 1'b0, 3'b000);

        // 7N2 0x3C with second stop bit low
        Receiver_Status = 32'h8F;
        send_frame(8'h3C, 1'b0, 2'b01, 1'b0);
        pin("t3_framing", 32'h3C, 1'b1, 3'b010);
        do_read();

        // Back-to-back 8N1 frames without a read
        Receiver_Status = 32'h51;
        send_frame(8'h11, 1'b0, 2'b11, 1'b0);
        send_frame(8'h22, 1'b0, 2'b11, 1'b0);
        pin("t4_overrun", 32'h22, 1'b1, 3'b100);

        // Read coincident with DONE, frame has a bad stop bit
        fork
            send_frame(8'h33, 1'b0, 2'b10, 1'b0);
            begin
                repeat (5) @(posedge clk);
                #1;
                while (cyc < pend_cycle - 1) begin
                    @(posedge clk); #1;
                end
                Receiver_Read = 1'b1;
                @(posedge clk); #1;
                Receiver_Read = 1'b0;
            end
        join
        pin("t4_read_done", 32'h33, 1'b1, 3'b010);
        do_read();

        // Start glitch shorter than half a bit
        @(posedge clk); #1;
        RX = 1'b0;
        repeat (4) @(posedge clk);
        #1 RX = 1'b1;
        repeat (40) @(posedge clk);
        pin("t5_glitch", 32'h33, 1'b0, 3'b000);

        // Out-of-range data field and stop field 00 at a truncating divisor
        Baud_Rate_Holding_Register = 32'd9_000_000;
        Receiver_Status = 32'h01;
        send_frame(8'hC3, 1'b0, 2'b11, 1'b0);
        pin("t_dbits_default", 32'hC3, 1'b1, 3'b000);
        do_read();
        Baud_Rate_Holding_Register = 32'd7_000_000;

        // Enable dropped mid-DATA: frame abandoned, nothing stored
        Receiver_Status = 32'h51;
        @(posedge clk); #1;
        hold_bit(1'b0, 14);
        hold_bit(1'b1, 14);
        hold_bit(1'b0, 14);
        Receiver_Status = 32'h50;
        RX = 1'b1;
        repeat (60) @(posedge clk);
        pin("t_enable_drop", 32'hC3, 1'b0, 3'b000);
        Receiver_Status = 32'h51;
        repeat (5) @(posedge clk);
        send_frame(8'h5A, 1'b0, 2'b11, 1'b0);
        pin("t_recover", 32'h5A, 1'b1, 3'b000);

        // Reset mid-DATA, then a clean frame
        @(posedge clk); #1;
        hold_bit(1'b0, 14);
        hold_bit(1'b1, 14);
        hold_bit(1'b0, 14);
        rst_n = 1'b0;
        RX = 1'b1;
        pin("t6_in_reset", 32'd0, 1'b0, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        send_frame(8'h7E, 1'b0, 2'b11, 1'b0);
        pin("t6_after_reset", 32'h7E, 1'b1, 3'b000);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
